divider_param: RTL and testbench

DIVIDER_PARAM -- requirements
Module: divider_param

---
 rtl/divider_pkg.sv | 14 +
 rtl/div_step.sv | 23 ++
 rtl/divider_param.sv | 212 +++++++++++++++++++++
 tb/tb_divider_param.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared FSM state type and iteration-count helper for the parameterised divider.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic int calc_iter(input int width, input int frac);
        return width + frac;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift a dividend bit into the partial remainder, subtract if it fits.
module div_step #(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        trial  = {rem_i, bit_i};
        diff   = trial - {1'b0, div_i};
        qbit_o = (trial >= {1'b0, div_i});
        // Remainder stays below the divisor, so WIDTH bits always suffice.
        rem_o  = qbit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_param.sv
// Iterative restoring divider: (a_in << FRAC) / b_in, one quotient bit per cycle, MSB first.
// Define DIV_SIGNED_EN to add the sgn port and two's-complement operand handling.
module divider_param
    import divider_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int FRAC  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclr,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef DIV_SIGNED_EN
    input  logic             sgn,
`endif
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out,
    output logic             dvz,
    output logic             ovf,
    output logic             busy,
    output logic             valid
);

    localparam int ITER = calc_iter(WIDTH, FRAC);
    localparam int NW   = ITER;
    localparam int CW   = $clog2(ITER);

    state_t           state_q, state_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [NW-1:0]    nq_q, nq_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zdiv_q, zdiv_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dvz_q, dvz_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] rem_nx;
    logic             qbit;
    logic             ovf_u;
    logic [WIDTH-1:0] q_fin, r_fin;
    logic             ovf_fin;

`ifdef DIV_SIGNED_EN
    localparam logic [NW-1:0] SLIM = NW'(1) << (WIDTH - 1);
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d;
    logic             aneg_q, aneg_d;
    logic [NW-1:0]    q_signed;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (nq_q[NW-1]),
        .div_i  (div_q),
        .rem_o  (rem_nx),
        .qbit_o (qbit)
    );

    if (FRAC > 0) begin : g_ovf_frac
        assign ovf_u = |nq_q[NW-1:WIDTH];
    end else begin : g_ovf_nofrac
        assign ovf_u = 1'b0;
    end

`ifdef DIV_SIGNED_EN
    // Divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend.
    always_comb begin
        a_mag    = (sgn && a_in[WIDTH-1]) ? -a_in : a_in;
        b_mag    = (sgn && b_in[WIDTH-1]) ? -b_in : b_in;
        q_signed = qneg_q ? -nq_q : nq_q;
        q_fin    = q_signed[WIDTH-1:0];
        r_fin    = aneg_q ? -rem_q : rem_q;
        if (sgn_q) begin
            ovf_fin = qneg_q ? (nq_q > SLIM) : (nq_q >= SLIM);
        end else begin
            ovf_fin = ovf_u;
        end
    end
`else
    always_comb begin
        a_mag   = a_in;
        b_mag   = b_in;
        q_fin   = nq_q[WIDTH-1:0];
        r_fin   = rem_q;
        ovf_fin = ovf_u;
    end
`endif

    always_comb begin
        state_d = state_q;
        nq_d    = nq_q;
        rem_d   = rem_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        zdiv_d  = zdiv_q;
        q_d     = q_q;
        r_d     = r_q;
        dvz_d   = dvz_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
`ifdef DIV_SIGNED_EN
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        aneg_d  = aneg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    q_d     = '0;
                    r_d     = '0;
                    dvz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    nq_d    = NW'(a_mag) << FRAC;
                    rem_d   = '0;
                    div_d   = b_mag;
                    cnt_d   = CW'(ITER - 1);
                    zdiv_d  = (b_in == '0);
                    state_d = (b_in == '0) ? DONE : CALC;
`ifdef DIV_SIGNED_EN
                    sgn_d   = sgn;
                    qneg_d  = sgn & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                    aneg_d  = sgn & a_in[WIDTH-1];
`endif
                end
            end
            CALC: begin
                nq_d  = {nq_q[NW-2:0], qbit};
                rem_d = rem_nx;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b1;
                if (zdiv_q) begin
                    dvz_d = 1'b1;
                end else begin
                    q_d   = q_fin;
                    r_d   = r_fin;
                    ovf_d = ovf_fin;
                end
            end
            default: state_d = IDLE;
        endcase
        // Synchronous clear overrides everything, including a coincident start.
        if (sclr) begin
            state_d = IDLE;
            q_d     = '0;
            r_d     = '0;
            dvz_d   = 1'b0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
            zdiv_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nq_q    <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            zdiv_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dvz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            aneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            nq_q    <= nq_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            zdiv_q  <= zdiv_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dvz_q   <= dvz_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
`ifdef DIV_SIGNED_EN
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            aneg_q  <= aneg_d;
`endif
        end
    end

    assign q_out = q_q;
    assign r_out = r_q;
    assign dvz   = dvz_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q != IDLE);
    assign valid = valid_q;

endmodule

// File: tb/tb_divider_param.sv
// Self-checking bench for divider_param: WIDTH=10 with FRAC=0 and FRAC=4 instances, arithmetic reference model.
module tb_divider_param;

    localparam int W = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, sclr;
    logic         start0, start4, sgn0;
    logic [W-1:0] a0, b0, a4, b4;
    logic [W-1:0] q0, r0, q4, r4;
    logic         dvz0, ovf0, busy0, valid0;
    logic         dvz4, ovf4, busy4, valid4;

    int n_checks = 0;
    int n_fail   = 0;

    divider_param #(.WIDTH(W), .FRAC(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sclr(sclr), .start(start0),
        .a_in(a0), .b_in(b0),
`ifdef DIV_SIGNED_EN
        .sgn(sgn0),
`endif
        .q_out(q0), .r_out(r0), .dvz(dvz0), .ovf(ovf0), .busy(busy0), .valid(valid0)
    );

    divider_param #(.WIDTH(W), .FRAC(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sclr(sclr), .start(start4),
        .a_in(a4), .b_in(b4),
`ifdef DIV_SIGNED_EN
        .sgn(1'b0),
`endif
        .q_out(q4), .r_out(r4), .dvz(dvz4), .ovf(ovf4), .busy(busy4), .valid(valid4)
    );

    // Reference: exact integer division of (a * 2^frac) by b; SV division truncates toward zero.
    function automatic void model(input int frac, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit sg, output logic [W-1:0] eq, output logic [W-1:0] er,
                                  output logic edz, output logic eov, output int elat);
        longint na, nb, n, q, r;
        if (b == '0) begin
            eq = '0; er = '0; edz = 1'b1; eov = 1'b0; elat = 1;
            return;
        end
        edz  = 1'b0;
        elat = W + frac + 1;
        if (sg) begin
            na = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
            nb = b[W-1] ? longint'(b) - (longint'(1) << W) : longint'(b);
        end else begin
            na = longint'(a);
            nb = longint'(b);
        end
        n = na * (longint'(1) << frac);
        q = n / nb;
        r = n % nb;
        if (sg) eov = (q > 511) || (q < -512);
        else    eov = (q > 1023);
        eq = W'(q);
        er = W'(r);
    endfunction

    task automatic drive(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sg, input logic st);
        if (sel == 0) begin
            a0 = a; b0 = b; sgn0 = sg; start0 = st;
        end else begin
            a4 = a; b4 = b; start4 = st;
        end
    endtask

    task automatic sample(input int sel, output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic dz, output logic ov, output logic bs, output logic vl);
        if (sel == 0) begin
            q = q0; r = r0; dz = dvz0; ov = ovf0; bs = busy0; vl = valid0;
        end else begin
            q = q4; r = r4; dz = dvz4; ov = ovf4; bs = busy4; vl = valid4;
        end
    endtask

    // Called #1 after a clock edge. Operands are scrambled right after acceptance.
    task automatic do_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b, input bit sg,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                         output logic ov, output int lat, output bit proto_ok);
        logic [W-1:0] tq, tr;
        logic tdz, tov, tbs, tvl;
        q = 'x; r = 'x; dz = 1'bx; ov = 1'bx; lat = -1;
        drive(sel, a, b, sg, 1'b1);
        @(posedge clk); #1;
        drive(sel, W'($urandom), W'($urandom), ~sg, 1'b0);
        sample(sel, tq, tr, tdz, tov, tbs, tvl);
        proto_ok = (tq == '0) && (tr == '0) && !tdz && !tov && tbs && !tvl;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            sample(sel, tq, tr, tdz, tov, tbs, tvl);
            if (tvl) begin
                lat = c; q = tq; r = tr; dz = tdz; ov = tov;
                proto_ok = proto_ok && !tbs;
                break;
            end
            proto_ok = proto_ok && tbs;
        end
        @(posedge clk); #1;
        sample(sel, tq, tr, tdz, tov, tbs, tvl);
        proto_ok = proto_ok && !tvl && !tbs && (tq === q) && (tr === r);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclr = 1'b0;
        drive(0, '0, '0, 1'b0, 1'b0);
        drive(1, '0, '0, 1'b0, 1'b0);
        #2;
        n_checks++;
        if ({q0, r0, dvz0, ovf0, busy0, valid0} !== '0) begin
            n_fail++;
            $display("FAIL reset0: q=%0d r=%0d dvz=%b ovf=%b busy=%b valid=%b, expected all 0",
                     q0, r0, dvz0, ovf0, busy0, valid0);
        end
        n_checks++;
        if ({q4, r4, dvz4, ovf4, busy4, valid4} !== '0) begin
            n_fail++;
            $display("FAIL reset4: q=%0d r=%0d dvz=%b ovf=%b busy=%b valid=%b, expected all 0",
                     q4, r4, dvz4, ovf4, busy4, valid4);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ops(input int sel, input bit signed_mode, input int n_rand);
        logic [W-1:0] ta[4], tb[4], a, b, q, r, eq, er;
        logic dz, ov, edz, eov;
        bit sg, pok;
        int lat, elat, n_dir;
        if (sel == 1) begin
            ta[0] = 10'd1023; tb[0] = 10'd1;
            ta[1] = 10'd16;   tb[1] = 10'd8;
            n_dir = 2;
        end else if (signed_mode) begin
            ta[0] = 10'd949; tb[0] = 10'd11;
            ta[1] = 10'd512; tb[1] = 10'd1023;
            n_dir = 2;
        end else begin
            ta[0] = 10'd546; tb[0] = 10'd2;
            ta[1] = 10'd24;  tb[1] = 10'd771;
            ta[2] = 10'd75;  tb[2] = 10'd11;
            ta[3] = 10'd57;  tb[3] = 10'd0;
            n_dir = 4;
        end
        for (int i = 0; i < n_dir + n_rand; i++) begin
            if (i < n_dir) begin
                a = ta[i]; b = tb[i]; sg = signed_mode;
            end else begin
                a  = W'($urandom);
                b  = ($urandom_range(0, 5) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
                sg = signed_mode && ($urandom_range(0, 3) != 0);
            end
            model((sel == 1) ? 4 : 0, a, b, sg, eq, er, edz, eov, elat);
            do_op(sel, a, b, sg, q, r, dz, ov, lat, pok);
            n_checks++;
            if ({q, r, dz, ov} !== {eq, er, edz, eov}) begin
                n_fail++;
                $display("FAIL result[sel%0d sg%0b a=%0d b=%0d]: q=%0d r=%0d dvz=%b ovf=%b, expected q=%0d r=%0d dvz=%b ovf=%b",
                         sel, sg, a, b, q, r, dz, ov, eq, er, edz, eov);
            end
            n_checks++;
            if (lat != elat) begin
                n_fail++;
                $display("FAIL latency[sel%0d a=%0d b=%0d]: valid after edge %0d, expected edge %0d",
                         sel, a, b, lat, elat);
            end
            n_checks++;
            if (!pok) begin
                n_fail++;
                $display("FAIL protocol[sel%0d a=%0d b=%0d]: busy/valid/clear sequence wrong, expected clear+busy then one-cycle valid",
                         sel, a, b);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] eq, er, q, r, tq, tr;
        logic edz, eov, dz, ov, tdz, tov, tbs, tvl;
        int elat, lat, extra;
        model(0, 10'd75, 10'd11, 1'b0, eq, er, edz, eov, elat);
        lat = -1; extra = 0; q = 'x; r = 'x; dz = 1'bx; ov = 1'bx;
        drive(0, 10'd75, 10'd11, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 10'd1000, 10'd3, 1'b0, 1'b1);
        for (int c = 1; c <= 26; c++) begin
            @(posedge clk); #1;
            sample(0, tq, tr, tdz, tov, tbs, tvl);
            if (tvl && lat < 0) begin
                lat = c; q = tq; r = tr; dz = tdz; ov = tov;
            end else if (tvl || (c > 11 && tbs)) begin
                extra++;
            end
            if (c == 11) start0 = 1'b0;
        end
        n_checks++;
        if ({q, r, dz, ov} !== {eq, er, edz, eov}) begin
            n_fail++;
            $display("FAIL ignore_start result: q=%0d r=%0d dvz=%b ovf=%b, expected q=%0d r=%0d dvz=%b ovf=%b",
                     q, r, dz, ov, eq, er, edz, eov);
        end
        n_checks++;
        if (lat != elat) begin
            n_fail++;
            $display("FAIL ignore_start latency: %0d, expected %0d", lat, elat);
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL ignore_start restart: %0d extra busy/valid cycles, expected 0", extra);
        end
    endtask

    task automatic test_hold_sclr();
        logic [W-1:0] q, r;
        logic dz, ov;
        bit pok;
        int lat, extra;
        do_op(0, 10'd75, 10'd11, 1'b0, q, r, dz, ov, lat, pok);
        repeat (5) begin
            drive(0, W'($urandom), W'($urandom), 1'b0, 1'b0);
            @(posedge clk); #1;
        end
        n_checks++;
        if ({q0, r0, dvz0, ovf0} !== {10'd6, 10'd9, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL hold: q=%0d r=%0d dvz=%b ovf=%b, expected q=6 r=9 dvz=0 ovf=0", q0, r0, dvz0, ovf0);
        end
        sclr = 1'b1;
        @(posedge clk); #1 sclr = 1'b0;
        n_checks++;
        if ({q0, r0, dvz0, ovf0, busy0, valid0} !== '0) begin
            n_fail++;
            $display("FAIL sclr_idle: q=%0d r=%0d dvz=%b ovf=%b busy=%b valid=%b, expected all 0",
                     q0, r0, dvz0, ovf0, busy0, valid0);
        end
        sclr = 1'b1;
        drive(0, 10'd100, 10'd7, 1'b0, 1'b1);
        @(posedge clk); #1;
        sclr = 1'b0; start0 = 1'b0;
        extra = 0;
        repeat (15) begin
            if (busy0 || valid0) extra++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL sclr_with_start: %0d busy/valid cycles, expected 0", extra);
        end
        drive(0, 10'd100, 10'd7, 1'b0, 1'b1);
        @(posedge clk); #1 start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 sclr = 1'b1;
        @(posedge clk); #1 sclr = 1'b0;
        extra = 0;
        repeat (15) begin
            if (busy0 || valid0 || q0 != '0) extra++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL sclr_mid_calc: %0d nonzero busy/valid/q cycles, expected 0", extra);
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] q, r;
        logic dz, ov;
        bit pok;
        int lat, extra;
        do_op(0, 10'd546, 10'd2, 1'b0, q, r, dz, ov, lat, pok);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({q0, r0, dvz0, ovf0, busy0, valid0} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_idle: q=%0d r=%0d dvz=%b ovf=%b busy=%b valid=%b, expected all 0",
                     q0, r0, dvz0, ovf0, busy0, valid0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        drive(0, 10'd546, 10'd2, 1'b0, 1'b1);
        @(posedge clk); #1 start0 = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({q0, r0, dvz0, ovf0, busy0, valid0} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_calc: q=%0d r=%0d dvz=%b ovf=%b busy=%b valid=%b, expected all 0",
                     q0, r0, dvz0, ovf0, busy0, valid0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        extra = 0;
        repeat (15) begin
            if (busy0 || valid0) extra++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL async_reset_discard: %0d busy/valid cycles, expected 0", extra);
        end
        do_op(0, 10'd546, 10'd2, 1'b0, q, r, dz, ov, lat, pok);
        n_checks++;
        if ({q, r, dz, ov} !== {10'd273, 10'd0, 1'b0, 1'b0} || lat != 11 || !pok) begin
            n_fail++;
            $display("FAIL after_reset_op: q=%0d r=%0d dvz=%b ovf=%b lat=%0d proto=%0b, expected q=273 r=0 dvz=0 ovf=0 lat=11 proto=1",
                     q, r, dz, ov, lat, pok);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ops(0, 1'b0, 24);
        test_ops(1, 1'b0, 10);
`ifdef DIV_SIGNED_EN
        test_ops(0, 1'b1, 20);
`endif
        test_ignore_start();
        test_hold_sclr();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
